// File: rtl/fpu_issue_ctrl.sv
// Issue-side controller for the half-precision FPU: registers one decoded op, strobes it
// into the execution unit, waits for completion (with abort), and hands the result to writeback.
module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_sfpu_op,
   input  logic [2:0]  in_fpu_sel,
   input  logic [3:0]  in_float_control,
   input  logic [2:0]  in_fpu_pre,
   input  logic [2:0]  in_rnd,
   input  logic        in_rs1_en,
   input  logic        in_rs2_en,
   input  logic [31:0] in_rs1_d,
   input  logic [31:0] in_rs2_d,
   input  logic [15:0] in_fs1,
   input  logic [15:0] in_fs2,
   input  logic [15:0] in_fs3,
   input  logic [4:0]  in_rd,
   input  logic        in_rd_is_fp,
   output logic        valid_execution,
   output logic [23:0] sfpu_op,
   output logic [2:0]  fpu_sel,
   output logic [3:0]  float_control,
   output logic [2:0]  fpu_pre,
   output logic [2:0]  fpu_rounding,
   output logic        dec_i0_rs1_en_d,
   output logic        dec_i0_rs2_en_d,
   output logic [31:0] gpr_i0_rs1_d,
   output logic [31:0] gpr_i0_rs2_d,
   output logic [15:0] fs1_data,
   output logic [15:0] fs2_data,
   output logic [15:0] fs3_data,
   input  logic        fpu_complete,
   input  logic [15:0] fpu_result_1,
   input  logic [31:0] fpu_result_rd,
   input  logic [4:0]  sflags,
   input  logic        IV_exception,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic        wb_is_fp,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_flags,
   output logic [4:0]  fflags_accrued,
   input  logic        fflags_clr,
   output logic        timeout_err,
   output logic        busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_wb_hs;
   logic             w_timeout;
   logic             w_capture;

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign w_wb_hs   = (r_state == S_WB) && wb_ready;
   assign w_capture = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && fpu_complete;
   assign w_timeout = (r_state == S_WAIT) && !fpu_complete && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         valid_execution <= 1'b0;
         sfpu_op         <= '0;
         fpu_sel         <= '0;
         float_control   <= '0;
         fpu_pre         <= '0;
         fpu_rounding    <= '0;
         dec_i0_rs1_en_d <= 1'b0;
         dec_i0_rs2_en_d <= 1'b0;
         gpr_i0_rs1_d    <= '0;
         gpr_i0_rs2_d    <= '0;
         fs1_data        <= '0;
         fs2_data        <= '0;
         fs3_data        <= '0;
         wb_valid        <= 1'b0;
         wb_rd           <= '0;
         wb_is_fp        <= 1'b0;
         wb_data         <= '0;
         wb_flags        <= '0;
         fflags_accrued  <= '0;
         timeout_err     <= 1'b0;
      end else begin
         valid_execution <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  sfpu_op         <= in_sfpu_op;
                  fpu_sel         <= in_fpu_sel;
                  float_control   <= in_float_control;
                  fpu_pre         <= in_fpu_pre;
                  fpu_rounding    <= in_rnd;
                  dec_i0_rs1_en_d <= in_rs1_en;
                  dec_i0_rs2_en_d <= in_rs2_en;
                  gpr_i0_rs1_d    <= in_rs1_d;
                  gpr_i0_rs2_d    <= in_rs2_d;
                  fs1_data        <= in_fs1;
                  fs2_data        <= in_fs2;
                  fs3_data        <= in_fs3;
                  wb_rd           <= in_rd;
                  wb_is_fp        <= in_rd_is_fp;
                  valid_execution <= 1'b1;
                  r_state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= fpu_complete ? S_WB : S_WAIT;
            end
            S_WAIT: begin
               if (fpu_complete) begin
                  r_state <= S_WB;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
         endcase

         // Result capture: FP destinations are NaN-boxed into the 32-bit writeback word.
         if (w_capture) begin
            wb_valid <= 1'b1;
            wb_data  <= wb_is_fp ? {16'hFFFF, fpu_result_1} : fpu_result_rd;
            wb_flags <= sflags | {IV_exception, 4'b0000};
         end

         // A clear coinciding with a handshake leaves exactly the handshake's flags.
         if (fflags_clr) begin
            fflags_accrued <= w_wb_hs ? wb_flags : 5'b00000;
         end else if (w_wb_hs) begin
            fflags_accrued <= fflags_accrued | wb_flags;
         end

         if (w_timeout) begin
            timeout_err <= 1'b1;
         end else if (fflags_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: stimulus pushes expected writebacks into a queue,
// an independent monitor pops and compares them at each writeback handshake.
module tb_fpu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_sfpu_op;
   logic [2:0]  in_fpu_sel;
   logic [3:0]  in_float_control;
   logic [2:0]  in_fpu_pre;
   logic [2:0]  in_rnd;
   logic        in_rs1_en;
   logic        in_rs2_en;
   logic [31:0] in_rs1_d;
   logic [31:0] in_rs2_d;
   logic [15:0] in_fs1;
   logic [15:0] in_fs2;
   logic [15:0] in_fs3;
   logic [4:0]  in_rd;
   logic        in_rd_is_fp;
   logic        valid_execution;
   logic [23:0] sfpu_op;
   logic [2:0]  fpu_sel;
   logic [3:0]  float_control;
   logic [2:0]  fpu_pre;
   logic [2:0]  fpu_rounding;
   logic        dec_i0_rs1_en_d;
   logic        dec_i0_rs2_en_d;
   logic [31:0] gpr_i0_rs1_d;
   logic [31:0] gpr_i0_rs2_d;
   logic [15:0] fs1_data;
   logic [15:0] fs2_data;
   logic [15:0] fs3_data;
   logic        fpu_complete;
   logic [15:0] fpu_result_1;
   logic [31:0] fpu_result_rd;
   logic [4:0]  sflags;
   logic        IV_exception;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic        wb_is_fp;
   logic [31:0] wb_data;
   logic [4:0]  wb_flags;
   logic [4:0]  fflags_accrued;
   logic        fflags_clr;
   logic        timeout_err;
   logic        busy;

   typedef struct packed {
      logic [4:0]  rd;
      logic        fp;
      logic [31:0] data;
      logic [4:0]  flags;
   } wb_t;

   wb_t sb[$];
   int  n_tests = 0;
   int  n_fails = 0;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sfpu_op(in_sfpu_op), .in_fpu_sel(in_fpu_sel), .in_float_control(in_float_control),
      .in_fpu_pre(in_fpu_pre), .in_rnd(in_rnd),
      .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rs1_d(in_rs1_d), .in_rs2_d(in_rs2_d),
      .in_fs1(in_fs1), .in_fs2(in_fs2), .in_fs3(in_fs3),
      .in_rd(in_rd), .in_rd_is_fp(in_rd_is_fp),
      .valid_execution(valid_execution),
      .sfpu_op(sfpu_op), .fpu_sel(fpu_sel), .float_control(float_control), .fpu_pre(fpu_pre),
      .fpu_rounding(fpu_rounding), .dec_i0_rs1_en_d(dec_i0_rs1_en_d), .dec_i0_rs2_en_d(dec_i0_rs2_en_d),
      .gpr_i0_rs1_d(gpr_i0_rs1_d), .gpr_i0_rs2_d(gpr_i0_rs2_d),
      .fs1_data(fs1_data), .fs2_data(fs2_data), .fs3_data(fs3_data),
      .fpu_complete(fpu_complete), .fpu_result_1(fpu_result_1), .fpu_result_rd(fpu_result_rd),
      .sflags(sflags), .IV_exception(IV_exception),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_is_fp(wb_is_fp),
      .wb_data(wb_data), .wb_flags(wb_flags),
      .fflags_accrued(fflags_accrued), .fflags_clr(fflags_clr),
      .timeout_err(timeout_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic fp, input logic [31:0] data, input logic [4:0] fl);
      wb_t e;
      e.rd = rd; e.fp = fp; e.data = data; e.flags = fl;
      sb.push_back(e);
   endtask

   // Drives one op in cycle 0 and returns in cycle 1 (ISSUE) after checking the strobe and operands.
   task automatic accept(input logic [4:0] rd, input logic fp, input logic [15:0] fs1, input logic [23:0] op);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_rd = rd; in_rd_is_fp = fp; in_fs1 = fs1; in_sfpu_op = op;
      in_fpu_sel = 3'd2; in_rnd = 3'd1; in_float_control = 4'hA; in_fpu_pre = 3'd5;
      in_rs1_en = 1'b1; in_rs2_en = 1'b0; in_rs1_d = 32'h1234_5678; in_rs2_d = 32'h9ABC_DEF0;
      in_fs2 = 16'h4200; in_fs3 = 16'hC000;
      tick();
      in_valid = 1'b0; in_fs1 = '0; in_sfpu_op = '0; in_rs1_d = '0; in_fs3 = '0;
      chk("valid_execution_issue", valid_execution, 1);
      chk("sfpu_op_issue", sfpu_op, op);
      chk("fs1_data_issue", fs1_data, fs1);
      chk("fs3_data_issue", fs3_data, 16'hC000);
      chk("gpr_rs1_issue", gpr_i0_rs1_d, 32'h1234_5678);
      chk("fpu_rounding_issue", fpu_rounding, 3'd1);
   endtask

   // Scoreboard monitor: each writeback handshake pops one expected entry.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (!rst && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
               chk("wb_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("wb_rd", wb_rd, e.rd);
               chk("wb_is_fp", wb_is_fp, e.fp);
               chk("wb_data", wb_data, e.data);
               chk("wb_flags", wb_flags, e.flags);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcnt;
      rst = 1'b1; in_valid = 0; in_sfpu_op = 0; in_fpu_sel = 0; in_float_control = 0;
      in_fpu_pre = 0; in_rnd = 0; in_rs1_en = 0; in_rs2_en = 0; in_rs1_d = 0; in_rs2_d = 0;
      in_fs1 = 0; in_fs2 = 0; in_fs3 = 0; in_rd = 0; in_rd_is_fp = 0;
      fpu_complete = 0; fpu_result_1 = 0; fpu_result_rd = 0; sflags = 0; IV_exception = 0;
      wb_ready = 1; fflags_clr = 0;
      #2;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_wb_valid", wb_valid, 0);
      chk("reset_fflags", fflags_accrued, 0);
      chk("reset_valid_execution", valid_execution, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Single-cycle FP op
      accept(5'd5, 1'b1, 16'h3C00, 24'h000001);
      fpu_complete = 1; fpu_result_1 = 16'h4000; sflags = 5'b00001;
      push(5'd5, 1'b1, 32'hFFFF4000, 5'b00001);
      tick();
      fpu_complete = 0; sflags = 0;
      chk("t1_wb_valid_cycle2", wb_valid, 1);
      tick();
      chk("t1_fflags", fflags_accrued, 5'b00001);
      chk("t1_wb_valid_done", wb_valid, 0);
      chk("t1_in_ready", in_ready, 1);

      // Multi-cycle integer result
      accept(5'd3, 1'b0, 16'h4400, 24'h000100);
      vcnt = 1;
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (valid_execution) vcnt++;
         chk("t2_sfpu_op_hold", sfpu_op, 24'h000100);
         chk("t2_fs1_hold", fs1_data, 16'h4400);
         chk("t2_wb_valid_wait", wb_valid, 0);
      end
      tick();
      if (valid_execution) vcnt++;
      fpu_complete = 1; fpu_result_rd = 32'h0000_0007; sflags = 5'b00010;
      push(5'd3, 1'b0, 32'h0000_0007, 5'b00010);
      chk("t2_fs1_hold_complete", fs1_data, 16'h4400);
      tick();
      if (valid_execution) vcnt++;
      fpu_complete = 0; sflags = 0;
      chk("t2_wb_valid_cycle7", wb_valid, 1);
      chk("t2_valid_execution_count", vcnt, 1);
      tick();
      chk("t2_fflags", fflags_accrued, 5'b00011);

      // Writeback backpressure
      wb_ready = 0;
      accept(5'd9, 1'b1, 16'h5000, 24'h010000);
      fpu_complete = 1; fpu_result_1 = 16'hABCD; sflags = 5'b01000;
      push(5'd9, 1'b1, 32'hFFFFABCD, 5'b01000);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t3_wb_valid_hold", wb_valid, 1);
         chk("t3_wb_data_hold", wb_data, 32'hFFFFABCD);
         chk("t3_wb_flags_hold", wb_flags, 5'b01000);
         chk("t3_in_ready_low", in_ready, 0);
         chk("t3_fflags_no_accrue", fflags_accrued, 5'b00011);
         if (i == 0) begin
            fpu_complete = 1; fpu_result_1 = 16'h1111; sflags = 5'b11111;
         end else begin
            fpu_complete = 0; sflags = 0;
         end
         tick();
      end
      wb_ready = 1;
      tick();
      chk("t3_fflags_after_hs", fflags_accrued, 5'b01011);
      chk("t3_wb_valid_done", wb_valid, 0);

      // Timeout after 8 WAIT cycles
      accept(5'd10, 1'b1, 16'h6000, 24'h000010);
      for (int c = 2; c <= 9; c++) begin
         tick();
         chk("t4_busy_wait", busy, 1);
         chk("t4_timeout_err_low", timeout_err, 0);
         chk("t4_wb_valid_low", wb_valid, 0);
      end
      tick();
      chk("t4_timeout_err", timeout_err, 1);
      chk("t4_in_ready", in_ready, 1);
      chk("t4_busy", busy, 0);
      accept(5'd7, 1'b1, 16'h3800, 24'h000002);
      fpu_complete = 1; fpu_result_1 = 16'h3800; sflags = 5'b00000;
      push(5'd7, 1'b1, 32'hFFFF3800, 5'b00000);
      tick();
      fpu_complete = 0;
      chk("t4_next_wb_valid", wb_valid, 1);
      tick();
      chk("t4_next_fflags", fflags_accrued, 5'b01011);
      chk("t4_timeout_sticky", timeout_err, 1);

      // IV_exception with coincident clear
      accept(5'd12, 1'b0, 16'h7000, 24'h000020);
      fpu_complete = 1; fpu_result_rd = 32'hDEAD_BEEF; sflags = 5'b00000; IV_exception = 1;
      push(5'd12, 1'b0, 32'hDEAD_BEEF, 5'b10000);
      tick();
      fpu_complete = 0; IV_exception = 0;
      chk("t5_wb_flags", wb_flags, 5'b10000);
      fflags_clr = 1;
      tick();
      fflags_clr = 0;
      chk("t5_fflags_clr_hs", fflags_accrued, 5'b10000);
      chk("t5_timeout_cleared", timeout_err, 0);

      // Reset mid-WAIT
      accept(5'd4, 1'b1, 16'h1234, 24'h00ABCD);
      tick(); tick();
      chk("t6_busy_before_rst", busy, 1);
      rst = 1;
      #1;
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_sfpu_op", sfpu_op, 0);
      chk("t6_rst_fs1", fs1_data, 0);
      chk("t6_rst_wb_rd", wb_rd, 0);
      chk("t6_rst_fflags", fflags_accrued, 0);
      tick();
      rst = 0;
      fpu_complete = 1; fpu_result_1 = 16'hFFFF;
      tick(); tick();
      chk("t6_late_complete_wb_valid", wb_valid, 0);
      chk("t6_late_complete_busy", busy, 0);
      fpu_complete = 0;
      tick();
      chk("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
